// File: rtl/booth_pkg.sv
// Shared definitions for the radix-8 Booth encoder family:
// digit-count helper, sel code groups and the encoder FSM state type.
package booth_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } booth_enc_state_e;

    // sel code groups; the value of a window is -4*s[3] + 2*s[2] + s[1] + s[0]
    localparam logic [3:0] SEL_ZERO_P  = 4'd0;
    localparam logic [3:0] SEL_POS1_A  = 4'd1;
    localparam logic [3:0] SEL_POS1_B  = 4'd2;
    localparam logic [3:0] SEL_POS2_A  = 4'd3;
    localparam logic [3:0] SEL_POS2_B  = 4'd4;
    localparam logic [3:0] SEL_POS3_A  = 4'd5;
    localparam logic [3:0] SEL_POS3_B  = 4'd6;
    localparam logic [3:0] SEL_POS4    = 4'd7;
    localparam logic [3:0] SEL_NEG4    = 4'd8;
    localparam logic [3:0] SEL_NEG3_A  = 4'd9;
    localparam logic [3:0] SEL_NEG3_B  = 4'd10;
    localparam logic [3:0] SEL_NEG2_A  = 4'd11;
    localparam logic [3:0] SEL_NEG2_B  = 4'd12;
    localparam logic [3:0] SEL_NEG1_A  = 4'd13;
    localparam logic [3:0] SEL_NEG1_B  = 4'd14;
    localparam logic [3:0] SEL_ZERO_N  = 4'd15;

    // Radix-8 digits needed to cover a w-bit operand
    function automatic int num_digits(int w);
        return (w + 2) / 3;
    endfunction

    function automatic logic sel_is_zero(logic [3:0] s);
        return (s == SEL_ZERO_P) || (s == SEL_ZERO_N);
    endfunction

    // Signed digit value of a sel code, for decoders sharing this package
    function automatic int sel_value(logic [3:0] s);
        case (s)
            SEL_POS1_A, SEL_POS1_B: return 1;
            SEL_POS2_A, SEL_POS2_B: return 2;
            SEL_POS3_A, SEL_POS3_B: return 3;
            SEL_POS4:               return 4;
            SEL_NEG4:               return -4;
            SEL_NEG3_A, SEL_NEG3_B: return -3;
            SEL_NEG2_A, SEL_NEG2_B: return -2;
            SEL_NEG1_A, SEL_NEG1_B: return -1;
            default:                return 0;
        endcase
    endfunction

endpackage

// File: rtl/booth_window_sel.sv
// Combinational Booth window extractor: returns ext[3*idx+3 : 3*idx]
// and whether that window encodes a zero digit.
module booth_window_sel
    import booth_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int IDX_W      = 3,
    parameter int EXT_W      = 3 * NUM_DIGITS + 1
) (
    input  logic [EXT_W-1:0] i_ext,
    input  logic [IDX_W-1:0] i_idx,
    output logic [3:0]       o_sel,
    output logic             o_is_zero
);

    // Mux the overlapping 4-bit window selected by the index
    always_comb begin
        o_sel = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (i_idx == IDX_W'(d)) begin
                o_sel = i_ext[3*d +: 4];
            end
        end
        o_is_zero = sel_is_zero(o_sel);
    end

endmodule

// File: rtl/booth_encode_seq_16b.sv
// Sequential radix-8 Booth encoder: accepts one signed operand and streams
// its sel windows LSB-first with index and last flag over valid/ready.
// Optional build macro BOOTH_ENC_ZERO_SKIP_EN: zero-valued windows other than
// the last are skipped (one idle cycle each) instead of being emitted.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand
// EMIT  | presenting the window at r_idx until it is taken (or skipped)
module booth_encode_seq_16b
    import booth_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    localparam int NUM_DIGITS = num_digits(DATA_WIDTH),
    localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            sel,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  out_last
);

    localparam int              EXT_W    = 3 * NUM_DIGITS + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    booth_enc_state_e r_state;
    logic [EXT_W-1:0] r_ext;
    logic [IDX_W-1:0] r_idx;

    logic [EXT_W-1:0] w_ext_load;
    logic [3:0]       w_sel;
    logic             w_is_zero;
    logic             w_emit;
    logic             w_last;
    logic             w_skip;

    // Implicit zero below the LSB, sign extension above the MSB
    assign w_ext_load = EXT_W'($signed({B, 1'b0}));

    booth_window_sel #(
        .NUM_DIGITS (NUM_DIGITS),
        .IDX_W      (IDX_W),
        .EXT_W      (EXT_W)
    ) u_window_sel (
        .i_ext     (r_ext),
        .i_idx     (r_idx),
        .o_sel     (w_sel),
        .o_is_zero (w_is_zero)
    );

    assign w_emit = (r_state == EMIT);
    assign w_last = w_emit && (r_idx == LAST_IDX);

`ifdef BOOTH_ENC_ZERO_SKIP_EN
    // The last window is always emitted so the consumer always sees out_last
    assign w_skip = w_emit && w_is_zero && !w_last;
`else
    // Zero flag is not acted on when every window is emitted
    assign w_skip = w_is_zero & 1'b0;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = w_emit && !w_skip;
    assign sel       = w_emit ? w_sel : 4'd0;
    assign digit_idx = r_idx;
    assign out_last  = w_last;

    // Operand capture, digit stepping and return to IDLE after the last handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ext   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_ext   <= w_ext_load;
                        r_idx   <= '0;
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    if (w_skip) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end else if (out_ready) begin
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_encode_seq_16b.sv
// Self-checking bench for booth_encode_seq_16b (default and zero-skip builds).
module tb_booth_encode_seq_16b;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] B = 16'h0;
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  sel;
    logic [2:0]  digit_idx;
    logic        out_last;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] sel;
        int         idx;
        logic       last;
    } dig_t;

    dig_t                exp_q[$];
    logic signed [15:0]  cur_b = 16'sd0;
    longint              recon = 0;

    booth_encode_seq_16b dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .digit_idx (digit_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Window i of the operand: bits [3i+3:3i] of 2*B taken as a wide signed integer
    function automatic logic [3:0] model_sel(input logic [15:0] b, input int i);
        longint e;
        e = longint'($signed(b)) * 2;
        return 4'((e >>> (3 * i)) & 64'd15);
    endfunction

    function automatic int sel_val(input logic [3:0] s);
        int b3, b2, b1, b0;
        b3 = int'(s[3]); b2 = int'(s[2]); b1 = int'(s[1]); b0 = int'(s[0]);
        return -4 * b3 + 2 * b2 + b1 + b0;
    endfunction

    function automatic longint model_recon(input logic [15:0] b);
        longint acc = 0;
        for (int i = 0; i < 6; i++)
            acc += longint'(sel_val(model_sel(b, i))) * (longint'(1) << (3 * i));
        return acc;
    endfunction

    // Single compare process: builds expectations on accept, checks every valid cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            recon = 0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_digit: got sel=%0d idx=%0d required no digit", sel, digit_idx);
                end else begin
                    check("sel", sel, exp_q[0].sel);
                    check("idx", digit_idx, exp_q[0].idx);
                    check("last", out_last, exp_q[0].last);
                    if (out_ready) begin
                        recon += longint'(sel_val(sel)) * (longint'(1) << (3 * int'(digit_idx)));
                        if (out_last) begin
                            check("recon", recon, cur_b);
                            recon = 0;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                cur_b = B;
                recon = 0;
                for (int i = 0; i < 6; i++) begin
                    dig_t d;
                    d.sel  = model_sel(B, i);
                    d.idx  = i;
                    d.last = (i == 5);
`ifdef BOOTH_ENC_ZERO_SKIP_EN
                    if ((d.sel == 4'd0 || d.sel == 4'd15) && !d.last) continue;
`endif
                    exp_q.push_back(d);
                end
            end
        end
    end

    // Present an operand and hold in_valid through the accept edge; returns in cycle T+1
    task automatic send(input logic [15:0] b);
        int guard = 0;
        B = b;
        in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check("send_timeout", guard, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        B = 16'($urandom);
    endtask

    // Consume digits until the block is idle again; optionally random backpressure
    task automatic drain(input bit rnd);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b1;
        if (!in_ready) check("drain_timeout", guard, 0);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sel", sel, 0);
        check("rst_idx", digit_idx, 0);
        check("rst_last", out_last, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Hand-computed pins of the model
        check("pin_0001_d0", model_sel(16'h0001, 0), 2);
        check("pin_0001_d5", model_sel(16'h0001, 5), 0);
        check("pin_ffff_d0", model_sel(16'hFFFF, 0), 14);
        check("pin_ffff_d3", model_sel(16'hFFFF, 3), 15);
        check("pin_8000_d5", model_sel(16'h8000, 5), 14);
        check("pin_8000_d4", model_sel(16'h8000, 4), 0);
        check("pin_7fff_d0", model_sel(16'h7FFF, 0), 14);
        check("pin_7fff_d5", model_sel(16'h7FFF, 5), 1);
        check("pin_7fff_recon", model_recon(16'h7FFF), 32767);

        // Timing of B=1 with out_ready held high
        out_ready = 1'b1;
        begin
            int nv = 0;
            send(16'h0001);
            for (int c = 1; c <= 7; c++) begin
                if (c <= 6) begin
                    nv += int'(out_valid);
                    check("t_last", out_last, (c == 6));
                end
                if (c == 1) check("t_first_sel", sel, 2);
                check("t_in_ready", in_ready, (c == 7));
                if (c < 7) begin @(posedge clk); #1; end
            end
`ifdef BOOTH_ENC_ZERO_SKIP_EN
            check("t_valid_count", nv, 2);
`else
            check("t_valid_count", nv, 6);
`endif
            check("t_empty", exp_q.size(), 0);
        end

        // Directed operands
        send(16'hFFFF); drain(0);
        send(16'h8000); drain(0);
        send(16'h7FFF); drain(0);
        send(16'h0000); drain(0);

        // Backpressure at idx 2
        begin
            logic [3:0] h_sel;
            logic [2:0] h_idx;
            logic       h_last;
            int guard = 0;
            send(16'h5A5A);
            while (!(out_valid && digit_idx == 3'd2) && guard < 20) begin
                @(posedge clk); #1;
                guard++;
            end
            check("bp_reach_idx2", digit_idx, 2);
            out_ready = 1'b0;
            h_sel = sel; h_idx = digit_idx; h_last = out_last;
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                check("bp_valid", out_valid, 1);
                check("bp_sel", sel, h_sel);
                check("bp_idx", digit_idx, h_idx);
                check("bp_last", out_last, h_last);
            end
            drain(0);
        end

        // Reset asserted at idx 3
        begin
            int guard = 0;
            send(16'h5A5A);
            while (!(out_valid && digit_idx == 3'd3) && guard < 20) begin
                @(posedge clk); #1;
                guard++;
            end
            check("rst_reach_idx3", digit_idx, 3);
            rst_n = 1'b0;
            #1;
            check("mid_rst_out_valid", out_valid, 0);
            check("mid_rst_in_ready", in_ready, 1);
            check("mid_rst_idx", digit_idx, 0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
            check("post_rst_out_valid", out_valid, 0);
            send(16'h1235);
            check("post_rst_first_idx", digit_idx, 0);
            drain(0);
        end

        // Random operands with random backpressure
        for (int r = 0; r < 20; r++) begin
            send(16'($urandom));
            drain(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded, required completion");
        $fatal(1, "timeout");
    end

endmodule
